// File: rtl/wbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbi_pkg
// Purpose  : Shared constants for the Wishbone initiator: FSM state encoding,
//            response error flags and the data word reported on a timeout.
// Ports    : none (package)
// Options  : WBI_TIMEOUT_EN (consumed by wb_initiator, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package wbi_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam logic [1:0] WBI_IDLE = 2'd0;
    localparam logic [1:0] WBI_REQ  = 2'd1;
    localparam logic [1:0] WBI_WAIT = 2'd2;
    localparam logic [1:0] WBI_RESP = 2'd3;

    // Response error flags carried on o_rsp_err
    localparam logic WBI_ERR_NONE = 1'b0;
    localparam logic WBI_ERR_BUS  = 1'b1;

    // Read-data word returned when a transaction is abandoned by the timeout
    localparam logic [31:0] WBI_TIMEOUT_CODE = 32'hDEAD_0001;

endpackage
`default_nettype wire

// File: rtl/wbi_timeout.sv
`default_nettype none
// ============================================================================
// Module   : wbi_timeout
// Purpose  : Loadable down-counter with an expiry flag. Loaded with the cycle
//            budget minus one when a command is accepted; counts down while
//            enabled and flags expiry on the enabled cycle where it sits at 0.
// Ports    : i_clk       system clock
//            i_reset_n   synchronous active-low reset
//            i_load      load i_load_val (has priority over counting)
//            i_load_val  value to load
//            i_en        count enable (transaction in flight)
//            o_expired   budget exhausted this cycle (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module wbi_timeout #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_en && !i_load && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Purpose  : Single-outstanding Wishbone pipelined-mode master. Turns one
//            valid/ready command (we/addr/data/sel) into one bus cycle and
//            returns read data / error flag on a valid/ready response stream.
// Ports    : i_clk, i_reset_n            clock, synchronous active-low reset
//            i_cmd_* / o_cmd_ready       command stream
//            o_rsp_* / i_rsp_ready       response stream
//            o_wb_* / i_wb_*             Wishbone pipelined master interface
// Options  : `define WBI_TIMEOUT_EN to abort a transaction holding CYC for
//            TIMEOUT cycles (error response with WBI_TIMEOUT_CODE). Without
//            it the FSM waits indefinitely and TIMEOUT has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module wb_initiator
    import wbi_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    // command stream
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_we,
    input  logic [AW-1:0]   i_cmd_addr,
    input  logic [DW-1:0]   i_cmd_data,
    input  logic [DW/8-1:0] i_cmd_sel,
    // response stream
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_rsp_err,
    // Wishbone master
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            w_accept;
    logic            w_bus_done;
    logic            w_timeout;

    logic            r_wb_we;
    logic [AW-1:0]   r_wb_addr;
    logic [DW-1:0]   r_wb_data;
    logic [DW/8-1:0] r_wb_sel;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;

    assign w_accept = (r_state == WBI_IDLE) && i_cmd_valid;

`ifdef WBI_TIMEOUT_EN
    localparam int              c_tw   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tw-1:0] c_load = c_tw'(TIMEOUT - 1);

    // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th edge after accept
    wbi_timeout #(
        .WIDTH      (c_tw)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_accept),
        .i_load_val (c_load),
        .i_en       ((r_state == WBI_REQ) || (r_state == WBI_WAIT)),
        .o_expired  (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Slave completion. In REQ the ack/err only counts on the edge where the
    // strobe is taken (no stall), which is what lets zero-latency slaves work.
    always_comb begin
        w_bus_done = 1'b0;
        case (r_state)
            WBI_REQ:  w_bus_done = !i_wb_stall && (i_wb_ack || i_wb_err);
            WBI_WAIT: w_bus_done = i_wb_ack || i_wb_err;
            default:  w_bus_done = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= WBI_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded control outputs
    always_comb begin
        w_state_next = r_state;
        o_cmd_ready  = 1'b0;
        o_wb_cyc     = 1'b0;
        o_wb_stb     = 1'b0;
        o_rsp_valid  = 1'b0;
        case (r_state)
            WBI_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) w_state_next = WBI_REQ;
            end
            WBI_REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (w_bus_done || w_timeout) w_state_next = WBI_RESP;
                else if (!i_wb_stall)        w_state_next = WBI_WAIT;
            end
            WBI_WAIT: begin
                o_wb_cyc = 1'b1;
                if (w_bus_done || w_timeout) w_state_next = WBI_RESP;
            end
            default: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_state_next = WBI_IDLE;
            end
        endcase
    end

    // Bus request and response registers. Request fields only change on
    // accept, so they stay stable through any stall.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wb_sel   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= WBI_ERR_NONE;
        end else begin
            if (w_accept) begin
                r_wb_we    <= i_cmd_we;
                r_wb_addr  <= i_cmd_addr;
                r_wb_data  <= i_cmd_data;
                r_wb_sel   <= i_cmd_sel;
                r_rsp_data <= '0;
                r_rsp_err  <= WBI_ERR_NONE;
            end
            // A real completion beats a timeout on the same edge; err beats ack.
            if (w_bus_done) begin
                if (i_wb_err) begin
                    r_rsp_err  <= WBI_ERR_BUS;
                    r_rsp_data <= '0;
                end else begin
                    r_rsp_err  <= WBI_ERR_NONE;
                    r_rsp_data <= r_wb_we ? '0 : i_wb_data;
                end
            end else if (w_timeout) begin
                r_rsp_err  <= WBI_ERR_BUS;
                r_rsp_data <= DW'(WBI_TIMEOUT_CODE);
            end
        end
    end

    assign o_wb_we    = r_wb_we;
    assign o_wb_addr  = r_wb_addr;
    assign o_wb_data  = r_wb_data;
    assign o_wb_sel   = r_wb_sel;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Purpose  : Directed self-checking bench for wb_initiator. Inputs change and
//            outputs are sampled on the falling edge; the DUT acts on rising
//            edges. Timeout section is active only with WBI_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [3:0]    cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata, wb_rdata;
    logic [3:0]    wb_sel;
    logic          wb_stall, wb_ack, wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_initiator #(
        .AW(AW), .DW(DW), .TIMEOUT(16)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .i_cmd_sel   (cmd_sel),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_wdata),
        .o_wb_sel    (wb_sel),
        .i_wb_stall  (wb_stall),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err),
        .i_wb_data   (wb_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_sel   = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        wb_rdata = '0;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wb_bus", {wb_we, wb_addr, wb_wdata, wb_sel}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // ---------------- write 0xA5, sel 0001, addr 0, ack one cycle after STB
        @(negedge clk);
        cmd(1'b1, 30'h0, 32'h0000_00A5, 4'b0001);
        chk("w_cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);                           // after accept edge
        cmd_valid = 1'b0;
        chk("w_stb", {wb_cyc, wb_stb}, 2'b11);
        chk("w_bus", {wb_we, wb_wdata, wb_sel}, {1'b1, 32'h0000_00A5, 4'b0001});
        chk("w_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk);                           // strobe taken -> WAIT
        chk("w_wait", {wb_cyc, wb_stb, rsp_valid}, 3'b100);
        wb_ack = 1'b1;
        @(negedge clk);                           // 2 cycles after accept
        wb_ack = 1'b0;
        chk("w_rsp", {rsp_valid, wb_cyc, rsp_err}, 3'b100);
        chk("w_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("w_back_idle", {rsp_valid, cmd_ready}, 2'b01);

        // ---------------- read addr 0, stalled 3 cycles, data 0x0100_00A5
        cmd(1'b0, 30'h0, 32'h0, 4'b1111);
        wb_stall = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("r_stb_held", {wb_cyc, wb_stb, wb_we, wb_addr, wb_sel},
                {1'b1, 1'b1, 1'b0, 30'h0, 4'b1111});
            if (i == 3) wb_stall = 1'b0;
            @(negedge clk);
        end
        chk("r_wait", {wb_cyc, wb_stb}, 2'b10);
        wb_ack = 1'b1; wb_rdata = 32'h0100_00A5;
        @(negedge clk);
        wb_ack = 1'b0; wb_rdata = '0;
        chk("r_rsp", {rsp_valid, rsp_err, wb_cyc}, 3'b100);
        chk("r_rsp_data", rsp_data, 32'h0100_00A5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("r_back_idle", rsp_valid, 0);

        // ---------------- zero-latency slave: ack on the strobe edge
        cmd(1'b0, 30'h5, 32'h0, 4'b1111);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("z_addr", wb_addr, 30'h5);
        wb_ack = 1'b1; wb_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        wb_ack = 1'b0; wb_rdata = '0;
        chk("z_rsp", {rsp_valid, wb_cyc, rsp_err}, 3'b100);
        chk("z_rsp_data", rsp_data, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // ---------------- read with err+ack in WAIT
        cmd(1'b0, 30'h3, 32'h0, 4'b0011);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("e_bus", {wb_addr, wb_sel}, {30'h3, 4'b0011});
        @(negedge clk);
        wb_err = 1'b1; wb_ack = 1'b1; wb_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        wb_err = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
        chk("e_rsp", {wb_cyc, rsp_valid, rsp_err}, 3'b011);
        chk("e_rsp_data", rsp_data, 0);

        // ---------------- response back-pressure with a command waiting
        cmd(1'b1, 30'h7, 32'h1234_5678, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_valid, cmd_ready, wb_stb, wb_cyc}, 4'b1000);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle", {rsp_valid, cmd_ready, wb_stb}, 3'b010);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_new_req", {wb_stb, wb_we, wb_addr, wb_wdata},
            {1'b1, 1'b1, 30'h7, 32'h1234_5678});
        @(negedge clk);
        chk("bp_wait", {wb_cyc, wb_stb}, 2'b10);

        // ---------------- reset during WAIT, then a late ack
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_ack = 1'b1;
        chk("mr_after_rst", {wb_cyc, rsp_valid, cmd_ready}, 3'b001);
        chk("mr_addr_cleared", wb_addr, 0);
        @(negedge clk);
        wb_ack = 1'b0;
        chk("mr_late_ack", {wb_cyc, rsp_valid, cmd_ready}, 3'b001);

`ifdef WBI_TIMEOUT_EN
        // ---------------- timeout: slave never acks, TIMEOUT=16
        cmd(1'b0, 30'h9, 32'h0, 4'b1111);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_cyc_high", {wb_cyc, rsp_valid}, 2'b10);
            @(negedge clk);
        end
        chk("to_rsp", {wb_cyc, wb_stb, rsp_valid, rsp_err}, 4'b0011);
        chk("to_code", rsp_data, 32'hDEAD_0001);
        wb_ack = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0; rsp_ready = 1'b0;
        chk("to_idle", {rsp_valid, cmd_ready, wb_cyc}, 3'b010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
